// File: rtl/fma_lane_packer.sv
`default_nettype none
// ============================================================================
// fma_lane_packer
// Packs same-precision/same-op FMA requests into 1/2/4-lane datapath batches.
// Revision: 1.0
// ============================================================================
module fma_lane_packer #(
    parameter int TIMEOUT = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_precision,
    input  logic [1:0]   req_op,
    input  logic [63:0]  req_a,
    input  logic [63:0]  req_b,
    input  logic [63:0]  req_c,
    input  logic         flush,
    output logic         iss_valid,
    input  logic         iss_ready,
    output logic [1:0]   iss_mode,
    output logic [1:0]   iss_precision,
    output logic [1:0]   iss_op,
    output logic [255:0] iss_a,
    output logic [255:0] iss_b,
    output logic [255:0] iss_c,
    output logic [3:0]   iss_lane_mask,
    output logic [3:0]   iss_tag,
    output logic         err_illegal
);

    localparam int              TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0]   C_TMAX = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FILL  = 2'd1,
        S_ISSUE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           rdy_en_q;
    logic [2:0]     count_q, count_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [1:0]     prec_q, prec_d;
    logic [1:0]     op_q, op_d;
    logic [255:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [3:0]     mask_q, mask_d;
    logic [3:0]     tag_q, tag_d;
    logic           valid_q, valid_d;
    logic           err_q, err_d;
    logic           wr;
    logic [1:0]     lane;
    logic           w_illegal;
    logic           w_match;

    function automatic logic [2:0] cap_of(input logic [1:0] p);
        case (p)
            2'b11:   cap_of = 3'd1;
            2'b10:   cap_of = 3'd2;
            default: cap_of = 3'd4;
        endcase
    endfunction

    assign w_illegal = (req_precision == 2'b00);
    assign w_match   = (req_precision == prec_q) && (req_op == op_q);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        timer_d   = timer_q;
        prec_d    = prec_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        c_d       = c_q;
        mask_d    = mask_q;
        tag_d     = tag_q;
        err_d     = 1'b0;
        req_ready = 1'b0;
        wr        = 1'b0;
        lane      = count_q[1:0];

        case (state_q)
            S_IDLE: begin
                req_ready = rdy_en_q;
                if (req_valid && rdy_en_q) begin
                    if (w_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        wr      = 1'b1;
                        prec_d  = req_precision;
                        op_d    = req_op;
                        count_d = 3'd1;
                        timer_d = '0;
                        state_d = (cap_of(req_precision) == 3'd1) ? S_ISSUE : S_FILL;
                    end
                end
            end
            S_FILL: begin
                req_ready = rdy_en_q && (w_illegal || w_match);
                if (req_valid && req_ready) begin
                    // Any acceptance, even a dropped illegal one, restarts the idle timer.
                    timer_d = '0;
                    if (w_illegal) begin
                        err_d = 1'b1;
                    end else begin
                        wr      = 1'b1;
                        count_d = count_q + 3'd1;
                        if ((count_d == cap_of(prec_q)) || flush) begin
                            state_d = S_ISSUE;
                        end
                    end
                end else if (req_valid || flush || (timer_q == C_TMAX)) begin
                    // A stalled mismatching request closes the batch and opens the next one.
                    state_d = S_ISSUE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_ISSUE: begin
                if (iss_ready) begin
                    state_d = S_IDLE;
                    a_d     = '0;
                    b_d     = '0;
                    c_d     = '0;
                    mask_d  = '0;
                    count_d = '0;
                    tag_d   = tag_q + 4'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (wr) begin
            a_d[{lane, 6'd0} +: 64] = req_a;
            b_d[{lane, 6'd0} +: 64] = req_b;
            c_d[{lane, 6'd0} +: 64] = req_c;
            mask_d[lane]            = 1'b1;
        end

        valid_d = (state_d == S_ISSUE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            rdy_en_q <= 1'b0;
            count_q  <= '0;
            timer_q  <= '0;
            prec_q   <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            mask_q   <= '0;
            tag_q    <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            count_q  <= count_d;
            timer_q  <= timer_d;
            prec_q   <= prec_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            mask_q   <= mask_d;
            tag_q    <= tag_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign iss_valid     = valid_q;
    assign iss_mode      = prec_q;
    assign iss_precision = prec_q;
    assign iss_op        = op_q;
    assign iss_a         = a_q;
    assign iss_b         = b_q;
    assign iss_c         = c_q;
    assign iss_lane_mask = mask_q;
    assign iss_tag       = tag_q;
    assign err_illegal   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_fma_lane_packer.sv
`default_nettype none
// ============================================================================
// tb_fma_lane_packer
// Queue-based reference model and scoreboard for fma_lane_packer.
// Revision: 1.0
// ============================================================================
module tb_fma_lane_packer;

    localparam int TIMEOUT = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         req_valid = 1'b0;
    logic         req_ready;
    logic [1:0]   req_precision = 2'b00;
    logic [1:0]   req_op = 2'b00;
    logic [63:0]  req_a = '0, req_b = '0, req_c = '0;
    logic         flush = 1'b0;
    logic         iss_valid;
    logic         iss_ready = 1'b1;
    logic [1:0]   iss_mode, iss_precision, iss_op;
    logic [255:0] iss_a, iss_b, iss_c;
    logic [3:0]   iss_lane_mask, iss_tag;
    logic         err_illegal;

    fma_lane_packer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_precision(req_precision), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_c(req_c),
        .flush(flush),
        .iss_valid(iss_valid), .iss_ready(iss_ready),
        .iss_mode(iss_mode), .iss_precision(iss_precision), .iss_op(iss_op),
        .iss_a(iss_a), .iss_b(iss_b), .iss_c(iss_c),
        .iss_lane_mask(iss_lane_mask), .iss_tag(iss_tag),
        .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   prec;
        logic [1:0]   op;
        logic [255:0] a, b, c;
        logic [3:0]   mask;
        logic [3:0]   tag;
    } batch_t;

    batch_t      sbq[$];
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model: sampled 1 time unit before each rising edge
    logic [63:0] ea[$], eb[$], ec[$];
    logic [1:0]  m_prec, m_op;
    bit          m_issue, m_rdy, m_err;
    int          m_tag, cyc, last_acc;

    function automatic int cap(input logic [1:0] p);
        return (p == 2'b11) ? 1 : (p == 2'b10) ? 2 : 4;
    endfunction

    always begin
        bit exp_ready, filling, go;
        batch_t bt;
        @(negedge clk); #4;
        if (!rst_n) begin
            ea.delete(); eb.delete(); ec.delete(); sbq.delete();
            m_issue = 0; m_rdy = 0; m_err = 0; m_tag = 0; m_prec = 0; m_op = 0;
        end else begin
            filling   = (ea.size() != 0);
            exp_ready = 0;
            if (m_rdy && !m_issue)
                exp_ready = !filling || req_precision == 2'b00 ||
                            (req_precision == m_prec && req_op == m_op);
            chk("req_ready", req_ready, exp_ready);
            chk("iss_valid", iss_valid, m_issue);
            chk("err_illegal", err_illegal, m_err);
            m_err = 0;
            go = 0;
            if (m_issue) begin
                if (iss_ready) begin
                    m_issue = 0;
                    m_tag = (m_tag + 1) % 16;
                end
            end else if (req_valid && exp_ready && req_precision == 2'b00) begin
                m_err = 1;
                last_acc = cyc;
            end else if (req_valid && exp_ready) begin
                if (!filling) begin
                    m_prec = req_precision;
                    m_op = req_op;
                end
                ea.push_back(req_a); eb.push_back(req_b); ec.push_back(req_c);
                last_acc = cyc;
                if (ea.size() == cap(m_prec) || (flush && filling)) go = 1;
            end else if (filling) begin
                if (req_valid || flush || (cyc - last_acc) >= TIMEOUT) go = 1;
            end
            if (go) begin
                bt.prec = m_prec; bt.op = m_op; bt.tag = 4'(m_tag);
                bt.a = '0; bt.b = '0; bt.c = '0; bt.mask = '0;
                for (int k = 0; k < ea.size(); k++) begin
                    bt.a[64*k +: 64] = ea[k];
                    bt.b[64*k +: 64] = eb[k];
                    bt.c[64*k +: 64] = ec[k];
                    bt.mask[k] = 1'b1;
                end
                sbq.push_back(bt);
                ea.delete(); eb.delete(); ec.delete();
                m_issue = 1;
            end
            m_rdy = 1;
            cyc++;
        end
    end

    // ---------------- monitor: pops an expected batch when iss_valid rises
    bit     held = 0;
    batch_t cur;

    task automatic cmp_batch(input batch_t e);
        chk("iss_mode", iss_mode, e.prec);
        chk("iss_precision", iss_precision, e.prec);
        chk("iss_op", iss_op, e.op);
        chk("iss_a", iss_a, e.a);
        chk("iss_b", iss_b, e.b);
        chk("iss_c", iss_c, e.c);
        chk("iss_lane_mask", iss_lane_mask, e.mask);
        chk("iss_tag", iss_tag, e.tag);
    endtask

    always begin
        @(negedge clk); #4;
        if (!rst_n) begin
            held = 0;
        end else if (iss_valid) begin
            if (!held) begin
                if (sbq.size() == 0) begin
                    total++; bad++;
                    $display("FAIL unexpected_batch actual=iss_valid required=no_batch t=%0t", $time);
                end else begin
                    cur = sbq.pop_front();
                    held = 1;
                    cmp_batch(cur);
                end
            end else begin
                cmp_batch(cur);
            end
            if (iss_ready) held = 0;
        end
    end

    // ---------------- stimulus
    task automatic send(input logic [1:0] p, input logic [1:0] o,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        bit done = 0;
        req_valid = 1'b1; req_precision = p; req_op = o;
        req_a = a; req_b = b; req_c = c;
        for (int i = 0; i < 100 && !done; i++) begin
            #4;
            done = req_ready;
            @(negedge clk);
        end
        if (!done) begin
            total++; bad++;
            $display("FAIL send_timeout actual=not_accepted required=accepted t=%0t", $time);
        end
        req_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        flush = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_req_ready"}, req_ready, 0);
        chk({nm, "_iss_valid"}, iss_valid, 0);
        chk({nm, "_err"}, err_illegal, 0);
        chk({nm, "_mode"}, {iss_mode, iss_precision, iss_op}, 0);
        chk({nm, "_abc"}, iss_a | iss_b | iss_c, 0);
        chk({nm, "_mask_tag"}, {iss_lane_mask, iss_tag}, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #4 check_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // four HP muls back to back
        for (int i = 0; i < 4; i++) send(2'b01, 2'b00, 64'h1000 + 64'(i), 64'h2000 + 64'(i), 64'h3000 + 64'(i));
        idle(4);
        // SP FMA then DP add: DP stalls and forms its own batch
        send(2'b10, 2'b11, 64'hAAAA_0001, 64'hBBBB_0001, 64'hCCCC_0001);
        send(2'b11, 2'b10, 64'hDEAD_BEEF_0000_0001, 64'h1, 64'h2);
        idle(4);
        // lone HP request closed by timeout
        send(2'b01, 2'b01, 64'h3C00, 64'h4000, 64'h4200);
        idle(TIMEOUT + 4);
        // datapath back-pressure during issue
        iss_ready = 1'b0;
        send(2'b11, 2'b11, 64'h0123_4567_89AB_CDEF, 64'h5, 64'h6);
        idle(6);
        iss_ready = 1'b1;
        idle(2);
        // illegal precision in IDLE
        send(2'b00, 2'b11, 64'h9, 64'h9, 64'h9);
        idle(3);
        // flush closes a partial HP batch
        send(2'b01, 2'b10, 64'h11, 64'h22, 64'h33);
        flush = 1'b1;
        @(negedge clk);
        idle(3);
        // reset in the middle of a pending SP batch
        send(2'b10, 2'b00, 64'h77, 64'h88, 64'h99);
        rst_n = 1'b0;
        @(negedge clk);
        #4 check_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        idle(TIMEOUT + 6);

        // randomized traffic with occasional quiet stretches for timeouts
        for (int i = 0; i < 3000; i++) begin
            if (i % 250 == 249) begin
                iss_ready = 1'b1;
                idle(TIMEOUT + 3);
            end
            iss_ready = ($urandom % 10) < 7;
            flush     = ($urandom % 25) == 0;
            req_valid = ($urandom % 4) != 0;
            if (($urandom % 3) == 0) begin
                int r = $urandom % 16;
                req_precision = (r == 0) ? 2'b00 : 2'(1 + (r % 3));
                req_op = 2'($urandom % 2);
            end
            req_a = {$urandom, $urandom};
            req_b = {$urandom, $urandom};
            req_c = {$urandom, $urandom};
            @(negedge clk);
        end
        iss_ready = 1'b1;
        idle(TIMEOUT + 10);
        #4 chk("scoreboard_drained", 256'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
